led_pattern_sequencer: RTL and testbench

- Switch-driven controller that sequences the 4 user LEDs through selectable animation patterns at a programmable step rate.
- Replaces the fixed free-running blink counter at the top level.
- Owns switch synchronisation and debounce, the step-rate prescaler, and the pattern state machine.
- Instantiated directly under the board top, between sw[3:0] and led[3:0].

---
 rtl/led_pattern_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Switch-driven LED animation sequencer: synchronises and debounces sw[3:0], then steps
// the selected pattern at a slow or fast prescaled rate, with pause and reload on mode change.
module led_pattern_sequencer #(
  parameter int unsigned TICK_BASE       = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic       step_pulse,
  output logic [1:0] mode_o,
  output logic       paused_o
);

  localparam int unsigned PresW = $clog2(TICK_BASE);
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PresW-1:0] LastSlow = PresW'(TICK_BASE - 1);
  localparam logic [PresW-1:0] LastFast = PresW'((TICK_BASE >> 2) - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StRun, StPause} state_e;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q, cand_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]       deb_q, deb_d;
  state_e           state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic [3:0]       led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic [1:0]       mode_q, mode_d;
  logic             fast_q, fast_d;
  logic             paused_q, paused_d;

  logic [3:0]       step_led, init_led;
  logic             step_dir;
  logic             mode_chg, fast_chg, pause_req;
  logic [PresW-1:0] p_last;

  // One counter for the whole vector: any bit moving restarts the stability window.
  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    if (sync2_q != cand_q) begin
      cand_d   = sync2_q;
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      deb_d = cand_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    init_led = 4'b0000;
    unique case (mode_q)
      2'b00: step_led = led_q + 4'd1;
      2'b01: begin
        step_led = {led_q[2:0], led_q[3]};
        init_led = 4'b0001;
      end
      2'b10: begin
        init_led = 4'b0001;
        // dir 0 = moving left; endpoints are shown once, then direction flips
        if (!dir_q) begin
          if (led_q == 4'b1000) begin
            step_led = 4'b0100;
            step_dir = 1'b1;
          end else begin
            step_led = led_q << 1;
          end
        end else begin
          if (led_q == 4'b0001) begin
            step_led = 4'b0010;
            step_dir = 1'b0;
          end else begin
            step_led = led_q >> 1;
          end
        end
      end
      2'b11: step_led = ~led_q;
      default: step_led = led_q;
    endcase
  end

  always_comb begin
    mode_chg  = (deb_q[1:0] != mode_q);
    fast_chg  = (deb_q[2] != fast_q);
    pause_req = deb_q[3];
    p_last    = fast_q ? LastFast : LastSlow;

    state_d = state_q;
    presc_d = presc_q;
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    mode_d  = deb_q[1:0];
    fast_d  = deb_q[2];

    unique case (state_q)
      StLoad: begin
        led_d   = init_led;
        presc_d = '0;
        dir_d   = 1'b0;
        state_d = pause_req ? StPause : StRun;
      end
      StRun: begin
        if (pause_req) state_d = StPause;
        if (fast_chg) begin
          presc_d = '0;
        end else if (!pause_req) begin
          if (presc_q == p_last) begin
            presc_d = '0;
            led_d   = step_led;
            dir_d   = step_dir;
            step_d  = 1'b1;
          end else begin
            presc_d = presc_q + PresW'(1);
          end
        end
      end
      StPause: begin
        if (!pause_req) state_d = StRun;
        if (fast_chg) presc_d = '0;
      end
      default: state_d = StLoad;
    endcase

    // A mode change outranks everything, including a step due this cycle.
    if (mode_chg) begin
      state_d = StLoad;
      presc_d = presc_q;
      led_d   = led_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
    end

    paused_d = (state_d == StPause);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      db_cnt_q <= '0;
      deb_q    <= '0;
      state_q  <= StLoad;
      presc_q  <= '0;
      led_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      mode_q   <= '0;
      fast_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      sync1_q  <= sw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      db_cnt_q <= db_cnt_d;
      deb_q    <= deb_d;
      state_q  <= state_d;
      presc_q  <= presc_d;
      led_q    <= led_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      fast_q   <= fast_d;
      paused_q <= paused_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;
  assign mode_o     = mode_q;
  assign paused_o   = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: expected LED steps are queued as stimulus is
// applied and popped on each step_pulse; timing and control outputs are checked inline.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] led;
  logic       step_pulse;
  logic [1:0] mode_o;
  logic       paused_o;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         last_valid = 0;
  int         interval_exp = 0;
  int         pops = 0;
  bit         ignore_sb = 0;
  bit         chk_coin = 0;
  logic [3:0] prev_led = '0;
  logic [3:0] sb_q[$];
  logic [3:0] pp[7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] l_ref;
  int         s_cyc;
  int         k;
  int         pulses;

  led_pattern_sequencer #(
    .TICK_BASE      (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .led       (led),
    .step_pulse(step_pulse),
    .mode_o    (mode_o),
    .paused_o  (paused_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (chk_coin && led !== prev_led) check("led_change_with_pulse", 32'(step_pulse), 32'd1);
    prev_led = led;
    if (step_pulse === 1'b1 && !ignore_sb) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check("step_led", 32'(led), 32'(sb_q.pop_front()));
      pops++;
      if (interval_exp != 0 && last_valid)
        check("step_interval", 32'(cyc - last_cyc), 32'(interval_exp));
      last_cyc   = cyc;
      last_valid = 1'b1;
    end
  endtask

  task automatic wait_steps(input int n, input int budget);
    int start;
    int t;
    start = pops;
    t = 0;
    while (pops - start < n && t < budget) begin
      tick();
      t++;
    end
    check("steps_seen", 32'(pops - start), 32'(n));
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget);
    int t;
    t = 0;
    while (mode_o !== m && t < budget) begin
      tick();
      t++;
    end
    check("mode_o", 32'(mode_o), 32'(m));
  endtask

  task automatic arm(input int interval);
    ignore_sb    = 1'b0;
    last_cyc     = cyc;
    last_valid   = 1'b1;
    interval_exp = interval;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 4'b0000;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_step_pulse", 32'(step_pulse), 32'h0);
    check("rst_mode_o", 32'(mode_o), 32'h0);
    check("rst_paused_o", 32'(paused_o), 32'h0);

    // Mode 00 binary count from reset, including the 1111 -> 0000 wrap.
    chk_coin = 1'b1;
    rst_n = 1'b1;
    arm(9);
    sb_q.push_back(4'b0001);
    wait_steps(1, 15);
    interval_exp = 8;
    for (int i = 2; i <= 16; i++) sb_q.push_back(4'(i));
    wait_steps(15, 15 * 8 + 10);
    chk_coin = 1'b0;

    // Mode 10 ping-pong.
    ignore_sb = 1'b1;
    sw = 4'b0010;
    wait_mode(2'b10, 20);
    tick();
    check("pingpong_init", 32'(led), 32'h1);
    arm(8);
    for (int i = 0; i < 7; i++) sb_q.push_back(pp[i]);
    wait_steps(7, 7 * 8 + 10);

    // Mode 01 walking one, short fast glitch, then a real fast change.
    ignore_sb = 1'b1;
    sw = 4'b0001;
    wait_mode(2'b01, 20);
    tick();
    check("walk_init", 32'(led), 32'h1);
    arm(8);
    sb_q.push_back(4'b0010);
    wait_steps(1, 12);
    sw = 4'b0101;
    repeat (3) tick();
    sw = 4'b0001;
    sb_q.push_back(4'b0100);
    sb_q.push_back(4'b1000);
    wait_steps(2, 2 * 8 + 4);
    tick();
    tick();
    sw = 4'b0101;
    sb_q.push_back(4'b0001);
    wait_steps(1, 10);
    last_valid   = 1'b0;
    interval_exp = 2;
    sb_q.push_back(4'b0010);
    sb_q.push_back(4'b0100);
    sb_q.push_back(4'b1000);
    sb_q.push_back(4'b0001);
    sb_q.push_back(4'b0010);
    wait_steps(5, 20);

    // Back to slow, then pause accepted mid-period.
    ignore_sb = 1'b1;
    sw = 4'b0001;
    repeat (12) tick();
    k = 0;
    while (step_pulse !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    check("slow_step_found", 32'(step_pulse), 32'd1);
    l_ref = led;
    arm(8);
    repeat (6) tick();
    sw = 4'b1001;
    sb_q.push_back(rotl(l_ref));
    wait_steps(1, 10);
    s_cyc = cyc;
    k = 0;
    while (paused_o !== 1'b1 && k < 12) begin
      tick();
      k++;
    end
    check("paused_o_set", 32'(paused_o), 32'd1);
    check("pause_latency", 32'(cyc - s_cyc), 32'd6);
    l_ref  = led;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    check("pause_no_pulse", 32'(pulses), 32'd0);
    check("pause_led_frozen", 32'(led), 32'(l_ref));
    sw = 4'b0001;
    k = 0;
    while (paused_o !== 1'b0 && k < 12) begin
      tick();
      k++;
    end
    check("paused_o_clear", 32'(paused_o), 32'd0);
    arm(3);
    sb_q.push_back(rotl(l_ref));
    wait_steps(1, 6);

    // Mode change lands on the cycle the prescaler would wrap.
    sw = 4'b0011;
    interval_exp = 8;
    repeat (8) tick();
    check("modechg_mode_o", 32'(mode_o), 32'h3);
    check("modechg_no_pulse", 32'(step_pulse), 32'd0);
    tick();
    check("modechg_led_init", 32'(led), 32'h0);
    arm(8);
    sb_q.push_back(4'b1111);
    sb_q.push_back(4'b0000);
    sb_q.push_back(4'b1111);
    wait_steps(3, 3 * 8 + 4);

    // Asynchronous reset mid-period.
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    sw    = 4'b0000;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_pulse", 32'(step_pulse), 32'h0);
    check("async_rst_mode_o", 32'(mode_o), 32'h0);
    check("async_rst_paused", 32'(paused_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    arm(9);
    sb_q.push_back(4'b0001);
    wait_steps(1, 15);
    interval_exp = 8;
    sb_q.push_back(4'b0010);
    wait_steps(1, 12);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
